// File: rtl/alu_decode_stage.sv
// alu_decode_stage
//   Registered RV32I decode stage between fetch and execute. Turns an
//   instruction word into the ALU operation code, operand selects, the
//   sign-extended immediate, register indices and memory/writeback/branch
//   control. Valid/ready on both sides; holds its bundle under back-pressure.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   flush                 synchronous; drops the held and the incoming instruction
//   in_valid/in_ready     fetch-side handshake
//   in_instr, in_pc       instruction word and its PC
//   out_valid/out_ready   execute-side handshake
//   out_pc .. illegal     registered decoded bundle
module alu_decode_stage #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [3:0]      alu_op,
  output logic [1:0]      src_a_sel,
  output logic            src_b_imm,
  output logic [XLEN-1:0] imm,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic            reg_write,
  output logic            mem_read,
  output logic            mem_write,
  output logic [2:0]      mem_funct3,
  output logic            branch,
  output logic            jump,
  output logic            jalr,
  output logic            illegal
);

  // ALU operation codes (RISCV.h)
  localparam logic [3:0] ALU_ADD    = 4'd0;
  localparam logic [3:0] ALU_SUB    = 4'd1;
  localparam logic [3:0] ALU_SLL    = 4'd2;
  localparam logic [3:0] ALU_SLT    = 4'd3;
  localparam logic [3:0] ALU_SLTU   = 4'd4;
  localparam logic [3:0] ALU_XOR    = 4'd5;
  localparam logic [3:0] ALU_SRL    = 4'd6;
  localparam logic [3:0] ALU_SRA    = 4'd7;
  localparam logic [3:0] ALU_OR     = 4'd8;
  localparam logic [3:0] ALU_AND    = 4'd9;
  localparam logic [3:0] ALU_BRANCH = 4'd10;
  localparam logic [3:0] ALU_BLT    = 4'd11;
  localparam logic [3:0] ALU_BGE    = 4'd12;
  localparam logic [3:0] ALU_BLTU   = 4'd13;
  localparam logic [3:0] ALU_BGEU   = 4'd14;
  localparam logic [3:0] ALU_JAL    = 4'd15;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [1:0] SRC_A_RS1  = 2'd0;
  localparam logic [1:0] SRC_A_PC   = 2'd1;
  localparam logic [1:0] SRC_A_ZERO = 2'd2;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [3:0]      alu_op;
    logic [1:0]      src_a_sel;
    logic            src_b_imm;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic [2:0]      mem_funct3;
    logic            branch;
    logic            jump;
    logic            jalr;
    logic            illegal;
  } bundle_t;

  bundle_t     dec;
  bundle_t     bundle_d, bundle_q;
  logic        out_valid_d, out_valid_q;
  logic        load;
  logic [31:0] imm32;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;

  function automatic logic [3:0] arith_op(input logic [2:0] f3, input logic alt);
    logic [3:0] op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];
  assign funct7 = in_instr[31:25];

  always_comb begin
    dec            = '0;
    imm32          = '0;
    dec.pc         = in_pc;
    dec.alu_op     = ALU_ADD;
    dec.src_a_sel  = SRC_A_RS1;
    dec.rs1        = in_instr[19:15];
    dec.rs2        = in_instr[24:20];
    dec.rd         = in_instr[11:7];
    dec.mem_funct3 = funct3;

    case (opcode)
      OPC_OP: begin
        dec.alu_op    = arith_op(funct3, in_instr[30]);
        dec.reg_write = 1'b1;
        if (!(funct7 == 7'b0000000 ||
              (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101))))
          dec.illegal = 1'b1;
      end
      OPC_OP_IMM: begin
        // instr[30] only distinguishes SRAI; for ADDI it is an immediate bit.
        dec.alu_op    = arith_op(funct3, (funct3 == 3'b101) && in_instr[30]);
        dec.src_b_imm = 1'b1;
        dec.reg_write = 1'b1;
        imm32         = {{20{in_instr[31]}}, in_instr[31:20]};
      end
      OPC_LOAD: begin
        dec.src_b_imm = 1'b1;
        dec.reg_write = 1'b1;
        dec.mem_read  = 1'b1;
        imm32         = {{20{in_instr[31]}}, in_instr[31:20]};
      end
      OPC_STORE: begin
        dec.src_b_imm = 1'b1;
        dec.mem_write = 1'b1;
        imm32         = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      end
      OPC_BRANCH: begin
        dec.branch = 1'b1;
        imm32      = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                      in_instr[30:25], in_instr[11:8], 1'b0};
        case (funct3)
          3'b000:  dec.alu_op = ALU_SUB;
          3'b001:  dec.alu_op = ALU_BRANCH;
          3'b100:  dec.alu_op = ALU_BLT;
          3'b101:  dec.alu_op = ALU_BGE;
          3'b110:  dec.alu_op = ALU_BLTU;
          3'b111:  dec.alu_op = ALU_BGEU;
          default: dec.illegal = 1'b1;
        endcase
      end
      OPC_JAL: begin
        dec.alu_op    = ALU_JAL;
        dec.src_a_sel = SRC_A_PC;
        dec.src_b_imm = 1'b1;
        dec.jump      = 1'b1;
        dec.reg_write = 1'b1;
        imm32         = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                         in_instr[20], in_instr[30:21], 1'b0};
      end
      OPC_JALR: begin
        dec.alu_op    = ALU_JAL;
        dec.src_a_sel = SRC_A_PC;
        dec.src_b_imm = 1'b1;
        dec.jump      = 1'b1;
        dec.jalr      = 1'b1;
        dec.reg_write = 1'b1;
        imm32         = {{20{in_instr[31]}}, in_instr[31:20]};
        if (funct3 != 3'b000) dec.illegal = 1'b1;
      end
      OPC_LUI: begin
        dec.src_a_sel = SRC_A_ZERO;
        dec.src_b_imm = 1'b1;
        dec.reg_write = 1'b1;
        imm32         = {in_instr[31:12], 12'b0};
      end
      OPC_AUIPC: begin
        dec.src_a_sel = SRC_A_PC;
        dec.src_b_imm = 1'b1;
        dec.reg_write = 1'b1;
        imm32         = {in_instr[31:12], 12'b0};
      end
      default: dec.illegal = 1'b1;
    endcase

    if (in_instr[1:0] != 2'b11) dec.illegal = 1'b1;

    dec.imm = XLEN'($signed(imm32));

    if (dec.illegal) begin
      dec.reg_write = 1'b0;
      dec.mem_read  = 1'b0;
      dec.mem_write = 1'b0;
      dec.branch    = 1'b0;
      dec.jump      = 1'b0;
      dec.jalr      = 1'b0;
    end
    if (dec.rd == 5'd0) dec.reg_write = 1'b0;
  end

  assign in_ready = !out_valid_q || out_ready;
  assign load     = in_valid && in_ready && !flush;

  always_comb begin
    bundle_d    = load ? dec : bundle_q;
    out_valid_d = out_valid_q;
    if (flush)          out_valid_d = 1'b0;
    else if (load)      out_valid_d = 1'b1;
    else if (out_ready) out_valid_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bundle_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      bundle_q    <= bundle_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_pc     = bundle_q.pc;
  assign alu_op     = bundle_q.alu_op;
  assign src_a_sel  = bundle_q.src_a_sel;
  assign src_b_imm  = bundle_q.src_b_imm;
  assign imm        = bundle_q.imm;
  assign rs1        = bundle_q.rs1;
  assign rs2        = bundle_q.rs2;
  assign rd         = bundle_q.rd;
  assign reg_write  = bundle_q.reg_write;
  assign mem_read   = bundle_q.mem_read;
  assign mem_write  = bundle_q.mem_write;
  assign mem_funct3 = bundle_q.mem_funct3;
  assign branch     = bundle_q.branch;
  assign jump       = bundle_q.jump;
  assign jalr       = bundle_q.jalr;
  assign illegal    = bundle_q.illegal;

endmodule

// File: tb/tb_alu_decode_stage.sv
// tb_alu_decode_stage
//   Scoreboard bench for alu_decode_stage: expected bundles are queued at
//   acceptance and compared when execute consumes them.
module tb_alu_decode_stage;

  localparam logic [3:0] ALU_ADD = 4'd0,  ALU_SUB = 4'd1,  ALU_SRA = 4'd7;
  localparam logic [3:0] ALU_BRANCH = 4'd10, ALU_BLTU = 4'd13, ALU_JAL = 4'd15;

  // control flags {reg_write, mem_read, mem_write, branch, jump, jalr, illegal}
  localparam logic [6:0] F_RW  = 7'b1000000;
  localparam logic [6:0] F_LD  = 7'b1100000;
  localparam logic [6:0] F_ST  = 7'b0010000;
  localparam logic [6:0] F_BR  = 7'b0001000;
  localparam logic [6:0] F_JP  = 7'b1000100;
  localparam logic [6:0] F_JR0 = 7'b0000110;
  localparam logic [6:0] F_ILL = 7'b0000001;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_instr, in_pc, out_pc, imm;
  logic [3:0]  alu_op;
  logic [1:0]  src_a_sel;
  logic        src_b_imm, reg_write, mem_read, mem_write, branch, jump, jalr, illegal;
  logic [4:0]  rs1, rs2, rd;
  logic [2:0]  mem_funct3;

  alu_decode_stage #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .alu_op(alu_op), .src_a_sel(src_a_sel), .src_b_imm(src_b_imm), .imm(imm),
    .rs1(rs1), .rs2(rs2), .rd(rd),
    .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
    .mem_funct3(mem_funct3), .branch(branch), .jump(jump), .jalr(jalr),
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [1:0]  sa;
    logic        sb;
    logic [31:0] imm;
    logic [6:0]  fl;
    bit          dp;     // check alu_op / src_a_sel
    bit [1:0]    chk;    // [1] check imm, [0] check src_b_imm
    logic [31:0] instr;
    logic [31:0] pc;
    bit          lat;    // consumed exactly one cycle after acceptance
    int          acc;
  } exp_t;

  exp_t        sbq[$];
  exp_t        mon_e;
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  logic [31:0] pc_ctr = 32'h0000_1000;
  logic [31:0] held_pc;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, want);
    end
  endtask

  function automatic exp_t mk(input logic [3:0] op, input logic [1:0] sa, input logic sb,
                              input logic [31:0] im, input logic [6:0] fl, input bit [1:0] chk);
    exp_t e;
    e = '{op: op, sa: sa, sb: sb, imm: im, fl: fl, dp: 1'b1, chk: chk,
          instr: '0, pc: '0, lat: 1'b0, acc: 0};
    return e;
  endfunction

  function automatic exp_t ill();
    exp_t e;
    e = mk(ALU_ADD, 2'd0, 1'b0, '0, F_ILL, 2'b00);
    e.dp = 1'b0;
    return e;
  endfunction

  // Consumer-side scoreboard: one pop per accepted bundle.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        check("spurious_out_valid", 32'd1, 32'd0);
      end else begin
        mon_e = sbq.pop_front();
        check("out_pc", out_pc, mon_e.pc);
        check("rs1", 32'(rs1), 32'(mon_e.instr[19:15]));
        check("rs2", 32'(rs2), 32'(mon_e.instr[24:20]));
        check("rd", 32'(rd), 32'(mon_e.instr[11:7]));
        check("mem_funct3", 32'(mem_funct3), 32'(mon_e.instr[14:12]));
        check("ctl", 32'({reg_write, mem_read, mem_write, branch, jump, jalr, illegal}),
              32'(mon_e.fl));
        if (mon_e.dp) begin
          check("alu_op", 32'(alu_op), 32'(mon_e.op));
          check("src_a_sel", 32'(src_a_sel), 32'(mon_e.sa));
        end
        if (mon_e.chk[1]) check("imm", imm, mon_e.imm);
        if (mon_e.chk[0]) check("src_b_imm", 32'(src_b_imm), 32'(mon_e.sb));
        if (mon_e.lat) check("latency", 32'(cyc), 32'(mon_e.acc + 1));
      end
    end
  end

  // Offer one instruction; returns one step after the accepting edge.
  task automatic issue(input logic [31:0] ins, input exp_t e, input bit lat);
    int unsigned n;
    n        = 0;
    in_valid = 1'b1;
    in_instr = ins;
    in_pc    = pc_ctr;
    e.instr  = ins;
    e.pc     = pc_ctr;
    e.lat    = lat;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      check("accept_timeout", 32'd0, 32'd1);
    end else begin
      e.acc = cyc;
      sbq.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    pc_ctr   = pc_ctr + 32'd4;
  endtask

  task automatic drain();
    int unsigned n;
    n = 0;
    while ((sbq.size() != 0 || out_valid) && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (sbq.size() != 0 || out_valid) check("drain_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_instr  = '0;
    in_pc     = '0;
    out_ready = 1'b1;
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_alu_op", 32'(alu_op), 32'd0);
    check("rst_src_a_sel", 32'(src_a_sel), 32'd0);
    check("rst_imm", imm, 32'd0);
    check("rst_out_pc", out_pc, 32'd0);
    check("rst_idx", 32'({rs1, rs2, rd}), 32'd0);
    check("rst_ctl", 32'({src_b_imm, reg_write, mem_read, mem_write, mem_funct3,
                          branch, jump, jalr, illegal}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Streaming decode with out_ready held high: one instruction per cycle.
    issue(32'h002081B3, mk(ALU_ADD, 2'd0, 1'b0, 'x, F_RW, 2'b01), 1'b1);          // add
    issue(32'h402081B3, mk(ALU_SUB, 2'd0, 1'b0, 'x, F_RW, 2'b01), 1'b1);          // sub
    issue(32'h40335293, mk(ALU_SRA, 2'd0, 1'b1, 32'h403, F_RW, 2'b11), 1'b1);     // srai
    issue(32'h00208463, mk(ALU_SUB, 2'd0, 1'b0, 32'd8, F_BR, 2'b11), 1'b1);       // beq
    issue(32'h00209463, mk(ALU_BRANCH, 2'd0, 1'b0, 32'd8, F_BR, 2'b11), 1'b1);    // bne
    issue(32'h0020E463, mk(ALU_BLTU, 2'd0, 1'b0, 32'd8, F_BR, 2'b11), 1'b1);      // bltu
    issue(32'h123450B7, mk(ALU_ADD, 2'd2, 1'b1, 32'h12345000, F_RW, 2'b11), 1'b1);// lui
    issue(32'h00001117, mk(ALU_ADD, 2'd1, 1'b1, 32'h1000, F_RW, 2'b11), 1'b1);    // auipc
    issue(32'hFFF00093, mk(ALU_ADD, 2'd0, 1'b1, 32'hFFFFFFFF, F_RW, 2'b11), 1'b1);// addi -1
    issue(32'h00C12283, mk(ALU_ADD, 2'd0, 1'b1, 32'd12, F_LD, 2'b11), 1'b1);      // lw
    issue(32'hFE512E23, mk(ALU_ADD, 2'd0, 1'b1, 32'hFFFFFFFC, F_ST, 2'b11), 1'b1);// sw
    issue(32'h010000EF, mk(ALU_JAL, 2'd1, 1'b1, 32'd16, F_JP, 2'b10), 1'b1);      // jal
    issue(32'h00008067, mk(ALU_JAL, 2'd1, 1'b1, 32'd0, F_JR0, 2'b10), 1'b1);      // jalr x0
    issue(32'hFFFFFFFF, ill(), 1'b1);
    issue(32'h402091B3, ill(), 1'b1);   // funct7 0100000 with funct3 001
    issue(32'h002081B1, ill(), 1'b1);   // instr[1:0] != 11
    drain();

    // Back-pressure: held bundle stays frozen, in_ready low, then B follows.
    out_ready = 1'b0;
    held_pc   = pc_ctr;
    issue(32'h00001117, mk(ALU_ADD, 2'd1, 1'b1, 32'h1000, F_RW, 2'b11), 1'b0);
    in_valid  = 1'b1;
    in_instr  = 32'h002081B3;
    in_pc     = pc_ctr;
    repeat (3) begin
      @(negedge clk);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_imm_frozen", imm, 32'h1000);
      check("bp_pc_frozen", out_pc, held_pc);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    issue(32'h002081B3, mk(ALU_ADD, 2'd0, 1'b0, 'x, F_RW, 2'b01), 1'b1);
    drain();

    // Flush with an empty stage: offered instruction is dropped.
    flush    = 1'b1;
    in_valid = 1'b1;
    in_instr = 32'h123450B7;
    in_pc    = pc_ctr;
    @(negedge clk);
    check("flush_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("flush_drop", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;

    // Flush while a bundle is held under back-pressure.
    out_ready = 1'b0;
    issue(32'h00C12283, mk(ALU_ADD, 2'd0, 1'b1, 32'd12, F_LD, 2'b11), 1'b0);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    sbq.delete();
    @(negedge clk);
    check("flush_held", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;

    // Asynchronous reset while a bundle is held.
    issue(32'h40335293, mk(ALU_SRA, 2'd0, 1'b1, 32'h403, F_RW, 2'b11), 1'b0);
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(out_valid), 32'd0);
    check("async_rst_imm", imm, 32'd0);
    check("async_rst_ctl", 32'({reg_write, alu_op}), 32'd0);
    sbq.delete();
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    issue(32'h00208463, mk(ALU_SUB, 2'd0, 1'b0, 32'd8, F_BR, 2'b11), 1'b1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
